// File: rtl/nms_window_sequencer.sv
// rtl/nms_window_sequencer.sv - 3x3 window sequencer for non-maximum suppression
module nms_window_sequencer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int MAG_W = 11,
  parameter int DIR_W = 2
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic [MAG_W-1:0]   pix_mag,
  input  logic [DIR_W-1:0]   pix_dir,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*MAG_W-1:0] win_mag,
  output logic [9*DIR_W-1:0] win_dir,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = MAG_W + DIR_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;

  state_e             state_q;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic [PW-1:0]      lb1_q [IMG_W];
  logic [PW-1:0]      lb2_q [IMG_W];
  logic [MAG_W-1:0]   sm_q [9];
  logic [MAG_W-1:0]   sm_d [9];
  logic [DIR_W-1:0]   sd_q [9];
  logic [DIR_W-1:0]   sd_d [9];
  logic [9*MAG_W-1:0] win_mag_q, win_mag_d;
  logic [9*DIR_W-1:0] win_dir_q, win_dir_d;
  logic               win_valid_q, frame_done_q;
  logic               accept, emit, last_col, last_row;
  logic [PW-1:0]      up1, up2;

  assign pix_ready  = (state_q == FILL || state_q == RUN) && (!win_valid_q || win_ready);
  assign accept     = pix_valid && pix_ready;
  assign last_col   = (col_q == COL_LAST);
  assign last_row   = (row_q == ROW_LAST);
  // Interior pixels only: the first two rows/columns have no complete neighbourhood yet
  assign emit       = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign up1        = lb1_q[col_q];
  assign up2        = lb2_q[col_q];

  assign win_mag    = win_mag_q;
  assign win_dir    = win_dir_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

  // Next shift-window contents: shift left, new column is {row r-2, row r-1, incoming}
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      sm_d[k] = sm_q[k];
      sd_d[k] = sd_q[k];
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sm_d[3*r]   = sm_q[3*r+1];
        sm_d[3*r+1] = sm_q[3*r+2];
        sd_d[3*r]   = sd_q[3*r+1];
        sd_d[3*r+1] = sd_q[3*r+2];
      end
      sm_d[2] = up2[PW-1:DIR_W];
      sd_d[2] = up2[DIR_W-1:0];
      sm_d[5] = up1[PW-1:DIR_W];
      sd_d[5] = up1[DIR_W-1:0];
      sm_d[8] = pix_mag;
      sd_d[8] = pix_dir;
    end
    win_mag_d = '0;
    win_dir_d = '0;
    for (int k = 0; k < 9; k++) begin
      win_mag_d[MAG_W*k +: MAG_W] = sm_d[k];
      win_dir_d[DIR_W*k +: DIR_W] = sd_d[k];
    end
  end

  // Line buffers: the older line moves down, the incoming pixel becomes line r-1
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[col_q] <= up1;
      lb1_q[col_q] <= {pix_mag, pix_dir};
    end
  end

  // Frame FSM, raster counters, shift window and registered window outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_mag_q    <= '0;
      win_dir_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        sm_q[k] <= '0;
        sd_q[k] <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        sm_q[k] <= sm_d[k];
        sd_q[k] <= sd_d[k];
      end
      if (emit) begin
        win_mag_q   <= win_mag_d;
        win_dir_q   <= win_dir_d;
        win_valid_q <= 1'b1;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL, RUN: begin
          if (accept) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            // Smallest legal frame ends on its first window pixel, so check the end first
            if (last_row && last_col) begin
              state_q <= FLUSH;
            end else if (state_q == FILL && row_q == ROW_TWO && col_q == COL_TWO) begin
              state_q <= RUN;
            end
          end
        end
        FLUSH: begin
          if (win_valid_q && win_ready) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nms_window_sequencer.sv
// tb/tb_nms_window_sequencer.sv - directed self-checking bench for nms_window_sequencer
module tb_nms_window_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] pix_mag;
  logic [1:0]  pix_dir;
  logic        pix_valid;
  logic        pix_ready;
  logic [98:0] win_mag;
  logic [17:0] win_dir;
  logic        win_valid;
  logic        win_ready;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int overlap = 0;
  logic [98:0] q_mag [$];
  logic [17:0] q_dir [$];
  int          q_cyc [$];

  nms_window_sequencer #(.IMG_W(5), .IMG_H(5), .MAG_W(11), .DIR_W(2)) dut (
    .clk(clk), .rstN(rst_n), .start(start),
    .pix_mag(pix_mag), .pix_dir(pix_dir), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_mag(win_mag), .win_dir(win_dir), .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Collect every handshaken window and every frame_done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid && win_ready) begin
        q_mag.push_back(win_mag);
        q_dir.push_back(win_dir);
        q_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (frame_done && win_valid) overlap++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window w (0..8) of a 5x5 frame whose pixel p has magnitude p, direction p%4
  function automatic logic [98:0] exp_mag(input int w);
    logic [98:0] v;
    int cr, cc, p;
    v = '0;
    cr = w / 3 + 1;
    cc = w % 3 + 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = (cr - 1 + r) * 5 + (cc - 1 + c);
        v[11*(3*r+c) +: 11] = 11'(p);
      end
    return v;
  endfunction

  function automatic logic [17:0] exp_dir(input int w);
    logic [17:0] v;
    int cr, cc, p;
    v = '0;
    cr = w / 3 + 1;
    cc = w % 3 + 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = (cr - 1 + r) * 5 + (cc - 1 + c);
        v[2*(3*r+c) +: 2] = 2'(p % 4);
      end
    return v;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int idx, input bit rnd);
    int g;
    int guard;
    if (rnd) begin
      g = $urandom_range(0, 1);
      repeat (g) begin
        @(negedge clk);
        pix_valid = 1'b0;
      end
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix_mag   = 11'(idx);
    pix_dir   = 2'(idx % 4);
    guard = 0;
    while (pix_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", guard < 50, 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int fd_before);
    int guard;
    guard = 0;
    while (fd_count == fd_before && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("frame_done_seen", fd_count, fd_before + 1);
    @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("win_valid_after_frame", win_valid, 0);
  endtask

  task automatic check_frame();
    check("win_count", q_mag.size(), 9);
    for (int w = 0; w < q_mag.size() && w < 9; w++) begin
      check($sformatf("win_mag[%0d]", w), q_mag[w], exp_mag(w));
      check($sformatf("win_dir[%0d]", w), q_dir[w], exp_dir(w));
    end
  endtask

  task automatic clear_q();
    q_mag.delete();
    q_dir.delete();
    q_cyc.delete();
  endtask

  initial begin
    int fd0;
    rst_n = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_mag = '0;
    pix_dir = '0;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_mag", win_mag, 0);
    check("rst_win_dir", win_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;

    // pix_valid while IDLE is never accepted
    pix_valid = 1'b1;
    pix_mag = 11'd77;
    repeat (3) begin
      @(negedge clk);
      check("idle_pix_ready", pix_ready, 0);
      check("idle_busy", busy, 0);
    end
    pix_valid = 1'b0;

    // Frame 1: continuous stream, window ready always high
    clear_q();
    fd0 = fd_count;
    pulse_start();
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 25; i++) send(i, 1'b0);
    wait_done(fd0);
    check_frame();
    if (q_mag.size() == 9) begin
      check("first_centre", q_mag[0][44 +: 11], 6);
      check("first_k0", q_mag[0][0 +: 11], 0);
      check("first_k8", q_mag[0][88 +: 11], 12);
      check("last_centre", q_mag[8][44 +: 11], 18);
      check("wrap_k3", q_mag[3][33 +: 11], 10);
      check("wrap_k4", q_mag[3][44 +: 11], 11);
      check("wrap_k5", q_mag[3][55 +: 11], 12);
      check("wrap_k0", q_mag[3][0 +: 11], 5);
      check("wrap_k6", q_mag[3][66 +: 11], 15);
      check("frame_done_latency", fd_cyc, q_cyc[8] + 1);
    end
    check("done_valid_overlap", overlap, 0);

    // Frame 2: stall the third window for four cycles
    clear_q();
    fd0 = fd_count;
    pulse_start();
    for (int i = 0; i < 15; i++) send(i, 1'b0);
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_mag = 11'd15;
    pix_dir = 2'd3;
    repeat (4) begin
      @(negedge clk);
      check("stall_win_valid", win_valid, 1);
      check("stall_pix_ready", pix_ready, 0);
      check("stall_win_mag", win_mag, exp_mag(2));
      check("stall_win_dir", win_dir, exp_dir(2));
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
    pix_valid = 1'b0;
    for (int i = 15; i < 25; i++) send(i, 1'b0);
    wait_done(fd0);
    check_frame();

    // Frame 3: pix_valid with random gaps
    clear_q();
    fd0 = fd_count;
    pulse_start();
    for (int i = 0; i < 25; i++) send(i, 1'b1);
    wait_done(fd0);
    check_frame();

    // Frame 4: asynchronous reset after pixel 13
    clear_q();
    fd0 = fd_count;
    pulse_start();
    for (int i = 0; i < 14; i++) send(i, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pix_ready", pix_ready, 0);
    check("arst_win_valid", win_valid, 0);
    check("arst_win_mag", win_mag, 0);
    check("arst_win_dir", win_dir, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_frame_done", fd_count, fd0);
    check("arst_idle", busy, 0);

    // Frame 5: fresh start after reset, with a stray start pulse mid-frame
    clear_q();
    fd0 = fd_count;
    pulse_start();
    for (int i = 0; i < 8; i++) send(i, 1'b0);
    pulse_start();
    check("midframe_busy", busy, 1);
    for (int i = 8; i < 25; i++) send(i, 1'b0);
    wait_done(fd0);
    check_frame();
    check("final_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
